// File: rtl/traffic_pkg.sv
// Shared types, default phase durations and per-approach lamp decode
// for the multi-approach traffic-light controller.
package traffic_pkg;

    localparam int unsigned DEF_NUM_DIR    = 4;
    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_GREEN_CYC  = 20;
    localparam int unsigned DEF_YELLOW_CYC = 4;
    localparam int unsigned DEF_ALLRED_CYC = 2;
    localparam int unsigned DEF_FLASH_HALF = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_FLASH
    } state_e;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    // Lamp set for one approach; only the served approach leaves red.
    function automatic lamp_t lamp_decode(state_e st, logic is_active, logic phase);
        lamp_t l;
        l.red    = 1'b1;
        l.yellow = 1'b0;
        l.green  = 1'b0;
        case (st)
            ST_GREEN: begin
                if (is_active) begin
                    l.red   = 1'b0;
                    l.green = 1'b1;
                end
            end
            ST_YELLOW: begin
                if (is_active) begin
                    l.red    = 1'b0;
                    l.yellow = 1'b1;
                end
            end
            ST_FLASH: begin
                l.red    = 1'b0;
                l.yellow = phase;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/rr_dir_select.sv
// Round-robin next-approach picker: first demanding approach after the
// current one (current checked last), or plain rotation with no demand.
module rr_dir_select #(
    parameter int unsigned NUM_DIR = 4,
    parameter int unsigned DIR_W   = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] demand,
    input  logic [DIR_W-1:0]   active_dir,
    output logic [DIR_W-1:0]   next_dir_c
);

    logic [DIR_W-1:0] idx;

    // Scan from the farthest offset down so the nearest demanding approach wins.
    always_comb begin
        idx        = '0;
        next_dir_c = DIR_W'((int'(active_dir) + 1) % int'(NUM_DIR));
        if (|demand) begin
            for (int k = int'(NUM_DIR); k >= 1; k--) begin
                idx = DIR_W'((int'(active_dir) + k) % int'(NUM_DIR));
                if (demand[idx]) begin
                    next_dir_c = idx;
                end
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// N-approach traffic-light controller: GREEN -> YELLOW -> ALL-RED rotation
// with demand-based skipping and a maintenance flashing-yellow override.
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_DIR    = DEF_NUM_DIR,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned GREEN_CYC  = DEF_GREEN_CYC,
    parameter int unsigned YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int unsigned ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int unsigned FLASH_HALF = DEF_FLASH_HALF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       flash,
    input  logic [NUM_DIR-1:0]         demand,
    output logic [NUM_DIR-1:0]         red_on,
    output logic [NUM_DIR-1:0]         yellow_on,
    output logic [NUM_DIR-1:0]         green_on,
    output logic [$clog2(NUM_DIR)-1:0] active_dir
);

    localparam int unsigned DIR_W = $clog2(NUM_DIR);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);
    localparam logic [DIR_W-1:0] DIR_LAST  = DIR_W'(NUM_DIR - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic               phase_q, phase_d;
    logic [NUM_DIR-1:0] red_q, red_d;
    logic [NUM_DIR-1:0] yellow_q, yellow_d;
    logic [NUM_DIR-1:0] green_q, green_d;
    logic [DIR_W-1:0]   next_dir;
    logic               expired;
    lamp_t              lamp;

    rr_dir_select #(
        .NUM_DIR (NUM_DIR),
        .DIR_W   (DIR_W)
    ) u_rr_dir_select (
        .demand     (demand),
        .active_dir (dir_q),
        .next_dir_c (next_dir)
    );

    assign expired = (cnt_q == '0);

    // Next-state, timer, approach and flash-phase logic; flash overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        phase_d = phase_q;

        if (flash) begin
            if (state_q != ST_FLASH) begin
                state_d = ST_FLASH;
                cnt_d   = FLASH_LD;
                phase_d = 1'b1;
            end else if (expired) begin
                cnt_d   = FLASH_LD;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ALLRED;
                        cnt_d   = ALLRED_LD;
                    end
                end
                ST_ALLRED: begin
                    if (!expired) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!start) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GREEN;
                        cnt_d   = GREEN_LD;
                        dir_d   = next_dir;
                    end
                end
                ST_GREEN: begin
                    if (expired) begin
                        state_d = ST_YELLOW;
                        cnt_d   = YELLOW_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_YELLOW: begin
                    if (expired) begin
                        state_d = ST_ALLRED;
                        cnt_d   = ALLRED_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_FLASH: begin
                    state_d = ST_ALLRED;
                    cnt_d   = ALLRED_LD;
                    phase_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Lamps decoded from next state so the registered outputs track the FSM.
    always_comb begin
        red_d    = '0;
        yellow_d = '0;
        green_d  = '0;
        lamp     = '0;
        for (int unsigned i = 0; i < NUM_DIR; i++) begin
            lamp        = lamp_decode(state_d, dir_d == DIR_W'(i), phase_d);
            red_d[i]    = lamp.red;
            yellow_d[i] = lamp.yellow;
            green_d[i]  = lamp.green;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dir_q    <= DIR_LAST;
            phase_q  <= 1'b0;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            phase_q  <= phase_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    assign red_on     = red_q;
    assign yellow_on  = yellow_q;
    assign green_on   = green_q;
    assign active_dir = dir_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi with default parameters (4 approaches).
module tb_traffic_ctrl_multi;

    localparam int K_RED = 0;
    localparam int K_GRN = 1;
    localparam int K_YEL = 2;
    localparam int K_FON = 3;
    localparam int K_FOFF = 4;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       flash;
    logic [3:0] demand;
    logic [3:0] red_on;
    logic [3:0] yellow_on;
    logic [3:0] green_on;
    logic [1:0] active_dir;

    int tests_run;
    int tests_failed;

    traffic_ctrl_multi dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .flash      (flash),
        .demand     (demand),
        .red_on     (red_on),
        .yellow_on  (yellow_on),
        .green_on   (green_on),
        .active_dir (active_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {red, yellow, green} for a lamp situation on approach dir.
    function automatic logic [11:0] exp_lamps(int kind, int dir);
        logic [3:0] one;
        one = 4'(1) << dir;
        case (kind)
            K_GRN:   return {~one, 4'h0, one};
            K_YEL:   return {~one, one, 4'h0};
            K_FON:   return {4'h0, 4'hF, 4'h0};
            K_FOFF:  return 12'h000;
            default: return {4'hF, 4'h0, 4'h0};
        endcase
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        flash   = 1'b0;
        demand  = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        start   = 1'b0;
        flash   = 1'b0;
        demand  = 4'h0;
        #1 reset_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({red_on, yellow_on, green_on} !== exp_lamps(K_RED, 0) || active_dir !== 2'd3) begin
            tests_failed++;
            $display("FAIL reset_state: lamps=%h dir=%0d expected lamps=%h dir=3",
                     {red_on, yellow_on, green_on}, active_dir, exp_lamps(K_RED, 0));
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            tests_run++;
            if ({red_on, yellow_on, green_on} !== exp_lamps(K_RED, 0) || active_dir !== 2'd3) begin
                tests_failed++;
                $display("FAIL idle_hold cycle %0d: lamps=%h dir=%0d expected lamps=%h dir=3",
                         i, {red_on, yellow_on, green_on}, active_dir, exp_lamps(K_RED, 0));
            end
        end
    endtask

    task automatic test_fixed_time();
        logic [11:0] exp;
        do_reset();
        start = 1'b1;
        for (int i = 1; i <= 29; i++) begin
            @(negedge clk);
            if (i <= 2)       exp = exp_lamps(K_RED, 0);
            else if (i <= 22) exp = exp_lamps(K_GRN, 0);
            else if (i <= 26) exp = exp_lamps(K_YEL, 0);
            else if (i <= 28) exp = exp_lamps(K_RED, 0);
            else              exp = exp_lamps(K_GRN, 1);
            tests_run++;
            if ({red_on, yellow_on, green_on} !== exp) begin
                tests_failed++;
                $display("FAIL fixed_time cycle %0d: lamps=%h expected %h",
                         i, {red_on, yellow_on, green_on}, exp);
            end
        end
        tests_run++;
        if (active_dir !== 2'd1) begin
            tests_failed++;
            $display("FAIL fixed_time_dir: dir=%0d expected 1", active_dir);
        end
    endtask

    task automatic test_demand_skip();
        logic [11:0] exp;
        do_reset();
        start = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            @(negedge clk);
            if (i <= 2)       exp = exp_lamps(K_RED, 0);
            else if (i <= 22) exp = exp_lamps(K_GRN, 0);
            else if (i <= 26) exp = exp_lamps(K_YEL, 0);
            else if (i <= 28) exp = exp_lamps(K_RED, 0);
            else if (i <= 48) exp = exp_lamps(K_GRN, 3);
            else if (i <= 52) exp = exp_lamps(K_YEL, 3);
            else if (i <= 54) exp = exp_lamps(K_RED, 0);
            else              exp = exp_lamps(K_GRN, 3);
            tests_run++;
            if ({red_on, yellow_on, green_on} !== exp) begin
                tests_failed++;
                $display("FAIL demand_skip cycle %0d: lamps=%h expected %h",
                         i, {red_on, yellow_on, green_on}, exp);
            end
            if (i == 29 || i == 55) begin
                tests_run++;
                if (active_dir !== 2'd3) begin
                    tests_failed++;
                    $display("FAIL demand_skip_dir cycle %0d: dir=%0d expected 3", i, active_dir);
                end
            end
            if (i == 23) demand = 4'b1000;
        end
        demand = 4'h0;
    endtask

    task automatic test_flash();
        logic [11:0] exp;
        do_reset();
        start = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            if (i <= 2)       exp = exp_lamps(K_RED, 0);
            else if (i <= 10) exp = exp_lamps(K_GRN, 0);
            else if (i <= 15) exp = exp_lamps(K_FON, 0);
            else if (i <= 20) exp = exp_lamps(K_FOFF, 0);
            else if (i <= 22) exp = exp_lamps(K_RED, 0);
            else              exp = exp_lamps(K_GRN, 1);
            tests_run++;
            if ({red_on, yellow_on, green_on} !== exp) begin
                tests_failed++;
                $display("FAIL flash cycle %0d: lamps=%h expected %h",
                         i, {red_on, yellow_on, green_on}, exp);
            end
            if (i == 15) begin
                tests_run++;
                if (active_dir !== 2'd0) begin
                    tests_failed++;
                    $display("FAIL flash_dir_retained: dir=%0d expected 0", active_dir);
                end
            end
            if (i == 10) flash = 1'b1;
            if (i == 20) flash = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1'b1;
        repeat (24) @(negedge clk);
        tests_run++;
        if ({red_on, yellow_on, green_on} !== exp_lamps(K_YEL, 0)) begin
            tests_failed++;
            $display("FAIL async_pre_yellow: lamps=%h expected %h",
                     {red_on, yellow_on, green_on}, exp_lamps(K_YEL, 0));
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({red_on, yellow_on, green_on} !== exp_lamps(K_RED, 0) || active_dir !== 2'd3) begin
            tests_failed++;
            $display("FAIL async_reset_immediate: lamps=%h dir=%0d expected lamps=%h dir=3",
                     {red_on, yellow_on, green_on}, active_dir, exp_lamps(K_RED, 0));
        end
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (i <= 4) begin
                if ({red_on, yellow_on, green_on} !== exp_lamps(K_RED, 0)) begin
                    tests_failed++;
                    $display("FAIL async_restart cycle %0d: lamps=%h expected %h",
                             i, {red_on, yellow_on, green_on}, exp_lamps(K_RED, 0));
                end
            end else if ({red_on, yellow_on, green_on} !== exp_lamps(K_GRN, 0) || active_dir !== 2'd0) begin
                tests_failed++;
                $display("FAIL async_restart_green: lamps=%h dir=%0d expected lamps=%h dir=0",
                         {red_on, yellow_on, green_on}, active_dir, exp_lamps(K_GRN, 0));
            end
            if (i == 2) start = 1'b1;
        end
    endtask

    task automatic test_start_drop();
        logic [11:0] exp;
        do_reset();
        start = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (i <= 2)       exp = exp_lamps(K_RED, 0);
            else if (i <= 22) exp = exp_lamps(K_GRN, 0);
            else if (i <= 26) exp = exp_lamps(K_YEL, 0);
            else              exp = exp_lamps(K_RED, 0);
            tests_run++;
            if ({red_on, yellow_on, green_on} !== exp) begin
                tests_failed++;
                $display("FAIL start_drop cycle %0d: lamps=%h expected %h",
                         i, {red_on, yellow_on, green_on}, exp);
            end
            if (i == 5) start = 1'b0;
        end
        tests_run++;
        if (active_dir !== 2'd0) begin
            tests_failed++;
            $display("FAIL start_drop_dir: dir=%0d expected 0", active_dir);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_fixed_time();
        test_demand_skip();
        test_flash();
        test_async_reset();
        test_start_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Parametrised N-approach traffic-light controller, the successor to the single-approach `top` controller. It drives per-direction red/yellow/green lamps and sequences GREEN → YELLOW → ALL-RED around the approaches. Empty approaches are skipped when demand sensors are present, and a maintenance flashing-yellow mode is provided. The block sits directly under the board top, between the sensor/switch inputs and the lamp drivers.

## Interface
Parameters:
- `NUM_DIR`, 4, number of approaches; valid range 2–8.
- `CNT_W`, 8, phase-timer width.
- `GREEN_CYC`, 20, green duration in clk cycles; valid range 1..2^CNT_W.
- `YELLOW_CYC`, 4, yellow duration in cycles; same range.
- `ALLRED_CYC`, 2, all-red clearance in cycles; same range.
- `FLASH_HALF`, 5, half-period of the flashing yellow in cycles; same range.

Ports:
- `clk`, in, 1, system clock.
- `reset_n`, in, 1, asynchronous, active-low reset.
- `start`, in, 1, run enable.
- `flash`, in, 1, maintenance flashing-yellow request.
- `demand`, in, NUM_DIR, per-approach vehicle-present sensors, synchronous to clk.
- `red_on`, out, NUM_DIR, red lamp per approach.
- `yellow_on`, out, NUM_DIR, yellow lamp per approach.
- `green_on`, out, NUM_DIR, green lamp per approach.
- `active_dir`, out, $clog2(NUM_DIR), currently served approach.

## Operation
- States: IDLE, ALLRED, GREEN, YELLOW, FLASH.
- Reset values:
  - state IDLE; `red_on` all 1; `yellow_on` and `green_on` all 0.
  - `active_dir` = NUM_DIR-1, so the first grant goes to approach 0.
  - Timer 0; flash phase 0.
- IDLE: all red. `start`=1 → ALLRED.
- ALLRED: all red for ALLRED_CYC cycles. On expiry:
  - `start`=0 → IDLE.
  - Otherwise select the next approach and go to GREEN.
- Next-approach selection:
  - `demand`==0: (active_dir+1) mod NUM_DIR. This is fixed-time fallback.
  - Otherwise: first set `demand` bit scanning active_dir+1, active_dir+2, … with wrap-around. active_dir itself is checked last.
  - `demand` is sampled only on the ALLRED expiry cycle.
- GREEN: `green_on[active_dir]`=1, all other approaches red, for GREEN_CYC cycles, then YELLOW.
- YELLOW: `yellow_on[active_dir]`=1, others red, for YELLOW_CYC cycles, then ALLRED.
- `start` falling during GREEN/YELLOW does not truncate the phase. The controller always completes to ALLRED, then goes to IDLE.
- FLASH:
  - `flash`=1 forces FLASH from any state, with priority over all other transitions.
  - All red and green lamps off. `yellow_on` all equal the flash phase, which starts at 1 and toggles every FLASH_HALF cycles.
  - `flash`=0 → ALLRED with a full ALLRED_CYC clearance; active_dir is retained.
- Lamp invariant: at most one `green_on` bit set, and never both green and yellow on one approach.

## Timing
- Phase timer: loads DUR-1 on state entry and decrements to 0. Expiry is at count 0, so each phase lasts exactly DUR cycles.
- Outputs are decoded from registered state, active_dir and flash phase only. There is no combinational input→output path.
- Inputs sampled at posedge t change the outputs after that edge (visible from cycle t+1).
- `reset_n` low mid-phase: outputs go to all-red immediately (asynchronous). Release resumes in IDLE.
- Simultaneous events:
  - `flash` beats `start` and timer expiry.
  - A timer expiry on the same edge as a `flash` rise still enters FLASH.

## Structure
- Package `traffic_pkg` holds:
  - the state enum typedef;
  - default duration localparams;
  - a lamp-vector decode function.
- Sub-module `rr_dir_select`: combinational round-robin next-approach picker (inputs `demand` and `active_dir`, output next dir). It is instantiated once.
- Timer and FSM live in `traffic_ctrl_multi`.

## Test plan
- Reset with defaults: red_on=4'b1111, yellow_on=0, green_on=0, active_dir=3. Behaviour is held while start=0.
- start=1, demand=0: 2 cycles all-red, then green_on=4'b0001 for 20 cycles, yellow_on=4'b0001 for 4, 2 all-red, then green_on=4'b0010.
- demand=4'b1000 during dir 0 yellow: the next green is dir 3 (dirs 1–2 skipped). If demand stays 4'b1000, dir 3 is re-granted after its ALLRED.
- flash=1 mid-GREEN:
  - Next cycle green_on=0, red_on=0, yellow_on=4'b1111 for 5 cycles, then 0 for 5.
  - Release: 2 cycles all-red, then green on the next approach after the retained active_dir.
- reset_n pulsed low mid-YELLOW: outputs all-red the same cycle. After release the state is IDLE and the sequence restarts at dir 0.
- start dropped mid-GREEN: green completes its 20 cycles, then yellow 4 and all-red 2, then IDLE with all red held.
